// File: rtl/datapath.sv
// Mini-SRC CPU datapath: shared 32-bit bus, R0-R3, PC, IR, MAR, MDR, Y, Z, HI/LO and a combinational ALU.
// Define DATAPATH_DIV_EN to build the signed divider; without it, opcode 01111 yields zero.
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic        Cin,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic [15:0] R0_15_out,
    input  logic        PCin,
    input  logic        IncPC,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    output logic [31:0] BusMuxOut,
    output logic [31:0] PCval,
    output logic [31:0] IRval,
    output logic [31:0] MARval
);

    logic [31:0] r_q [4];
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhigh_q, zlow_q;
    logic [31:0] bus;
    logic [63:0] alu_c;
    logic [3:0]  r_in;

    assign r_in = {R3in, R2in, R1in, R0in};

    // Walking from R15 down means the lowest selected index is the last to assign.
    always_comb begin
        bus = '0;
        if (|R0_15_out) begin
            for (int i = 15; i >= 0; i--) begin
                if (R0_15_out[i]) begin
                    bus = (i < 4) ? r_q[i[1:0]] : 32'h0;
                end
            end
        end else if (HIout) begin
            bus = hi_q;
        end else if (LOout) begin
            bus = lo_q;
        end else if (Zhighout) begin
            bus = zhigh_q;
        end else if (Zlowout) begin
            bus = zlow_q;
        end else if (PCout) begin
            bus = pc_q;
        end else if (MDRout) begin
            bus = mdr_q;
        end
    end

    logic [4:0]  amt;
    logic [31:0] sra;
    logic [63:0] ror_full, rol_full, prod;

    assign amt      = bus[4:0];
    assign sra      = $signed(y_q) >>> amt;
    assign ror_full = {y_q, y_q} >> amt;
    assign rol_full = {y_q, y_q} << amt;
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod     = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};

`ifdef DATAPATH_DIV_EN
    logic [31:0] quo, rem;

    // Zero divisor and MIN/-1 are pinned explicitly so neither depends on tool behaviour.
    always_comb begin
        quo = '0;
        rem = '0;
        if (bus == 32'h0) begin
            quo = 32'hFFFF_FFFF;
            rem = y_q;
        end else if (y_q == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
            quo = y_q;
            rem = 32'h0;
        end else begin
            quo = $signed(y_q) / $signed(bus);
            rem = $signed(y_q) % $signed(bus);
        end
    end
`endif

    always_comb begin
        alu_c = {32'h0, bus};
        case (opcode)
            5'b00011: alu_c = {32'h0, y_q + bus + {31'h0, Cin}};
            5'b00100: alu_c = {32'h0, y_q - bus};
            5'b00101: alu_c = {32'h0, y_q >> amt};
            5'b00110: alu_c = {32'h0, sra};
            5'b00111: alu_c = {32'h0, y_q << amt};
            5'b01000: alu_c = {32'h0, ror_full[31:0]};
            5'b01001: alu_c = {32'h0, rol_full[63:32]};
            5'b01010: alu_c = {32'h0, y_q & bus};
            5'b01011: alu_c = {32'h0, y_q | bus};
`ifdef DATAPATH_DIV_EN
            5'b01111: alu_c = {rem, quo};
`else
            5'b01111: alu_c = 64'h0;
`endif
            5'b10000: alu_c = prod;
            5'b10001: alu_c = {32'h0, 32'h0 - bus};
            5'b10010: alu_c = {32'h0, ~bus};
            default:  alu_c = {32'h0, bus};
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zhigh_q <= '0;
            zlow_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_in[i]) r_q[i] <= bus;
            end
            if (IncPC)       pc_q <= pc_q + 32'h1;
            else if (PCin)   pc_q <= bus;
            if (IRin)    ir_q    <= bus;
            if (MARin)   mar_q   <= bus;
            if (MDRin)   mdr_q   <= Read ? Mdatain : bus;
            if (Yin)     y_q     <= bus;
            if (HIin)    hi_q    <= bus;
            if (LOin)    lo_q    <= bus;
            if (Zhighin) zhigh_q <= alu_c[63:32];
            if (Zlowin)  zlow_q  <= alu_c[31:0];
        end
    end

    assign BusMuxOut = bus;
    assign PCval     = pc_q;
    assign IRval     = ir_q;
    assign MARval    = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed transfer scenarios plus randomized ALU operations
// checked against a plain-arithmetic reference model.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read;
    logic [4:0]  opcode;
    logic        Cin;
    logic        R0in, R1in, R2in, R3in;
    logic [15:0] R0_15_out;
    logic        PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
    logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout;
    logic [31:0] BusMuxOut, PCval, IRval, MARval;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .opcode(opcode), .Cin(Cin),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R0_15_out(R0_15_out),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout),
        .BusMuxOut(BusMuxOut), .PCval(PCval), .IRval(IRval), .MARval(MARval)
    );

    always #5 clock = ~clock;

    task automatic idle();
        clear = 0; Mdatain = '0; Read = 0; opcode = '0; Cin = 0;
        R0in = 0; R1in = 0; R2in = 0; R3in = 0; R0_15_out = '0;
        PCin = 0; IncPC = 0; MARin = 0; MDRin = 0; IRin = 0; Yin = 0;
        HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0;
        PCout = 0; MDRout = 0; HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); Mdatain = v; Read = 1; MDRin = 1; tick(); idle();
    endtask

    // Y <= a, then Z <= ALU(Y, b) with b presented through MDR.
    task automatic run_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic ci);
        load_mdr(a);
        MDRout = 1; Yin = 1; tick(); idle();
        load_mdr(b);
        MDRout = 1; opcode = op; Cin = ci; Zhighin = 1; Zlowin = 1; tick(); idle();
    endtask

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input logic ci);
        logic [31:0] r;
        longint sa, sb, q, m;
        int n;
        n  = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = a;
        case (op)
            5'd3:  return {32'h0, a + b + 32'(ci)};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a / (32'h1 << n)};
            5'd6:  begin for (int k = 0; k < n; k++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            5'd7:  return {32'h0, a * (32'h1 << n)};
            5'd8:  begin for (int k = 0; k < n; k++) r = {r[0], r[31:1]}; return {32'h0, r}; end
            5'd9:  begin for (int k = 0; k < n; k++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            5'd10: return {32'h0, a & b};
            5'd11: return {32'h0, a | b};
            5'd15: begin
`ifdef DATAPATH_DIV_EN
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                m = sa - q * sb;
                return {m[31:0], q[31:0]};
`else
                return 64'h0;
`endif
            end
            5'd16: begin q = sa * sb; return q; end
            5'd17: return {32'h0, 32'h0 - b};
            5'd18: return {32'h0, ~b};
            default: return {32'h0, b};
        endcase
    endfunction

    task automatic test_reset();
        idle(); load_mdr(32'hDEAD_BEEF);
        clear = 1; MDRin = 1; Read = 1; Mdatain = 32'h1234_5678; tick(); tick(); idle();
        checks++; if (PCval !== 0) begin errors++; $display("FAIL reset_pc got %h exp 0", PCval); end
        checks++; if (IRval !== 0) begin errors++; $display("FAIL reset_ir got %h exp 0", IRval); end
        checks++; if (MARval !== 0) begin errors++; $display("FAIL reset_mar got %h exp 0", MARval); end
        #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL bus_idle got %h exp 0", BusMuxOut); end
        MDRout = 1; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL reset_mdr got %h exp 0", BusMuxOut); end
        idle(); R0_15_out = 16'h000F; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL reset_r0 got %h exp 0", BusMuxOut); end
        idle(); HIout = 1; LOout = 1; Zhighout = 1; Zlowout = 1; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL reset_hi got %h exp 0", BusMuxOut); end
        // Y is only visible through the ALU: Z <= Y | 0.
        idle(); opcode = 5'b01011; Zlowin = 1; tick(); idle(); Zlowout = 1; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL reset_y got %h exp 0", BusMuxOut); end
        idle();
    endtask

    task automatic test_load_path();
        load_mdr(32'h12); MDRout = 1; R2in = 1; tick(); idle();
        load_mdr(32'h14); MDRout = 1; R3in = 1; tick(); idle();
        load_mdr(32'h18); MDRout = 1; R1in = 1; tick(); idle();
        R0_15_out = 16'h0004; #1;
        checks++; if (BusMuxOut !== 32'h12) begin errors++; $display("FAIL load_r2 got %h exp 12", BusMuxOut); end
        R0_15_out = 16'h0008; #1;
        checks++; if (BusMuxOut !== 32'h14) begin errors++; $display("FAIL load_r3 got %h exp 14", BusMuxOut); end
        R0_15_out = 16'h0002; #1;
        checks++; if (BusMuxOut !== 32'h18) begin errors++; $display("FAIL load_r1 got %h exp 18", BusMuxOut); end
        idle();
    endtask

    task automatic test_and();
        R0_15_out = 16'h0004; Yin = 1; tick(); idle();
        R0_15_out = 16'h0008; opcode = 5'b01010; Zlowin = 1; tick(); idle();
        Zlowout = 1; R1in = 1; tick(); idle();
        R0_15_out = 16'h0002; #1;
        checks++; if (BusMuxOut !== 32'h10) begin errors++; $display("FAIL and_r1 got %h exp 10", BusMuxOut); end
        idle();
    endtask

    task automatic test_fetch();
        clear = 1; tick(); idle();
        IncPC = 1; tick(); idle();
        checks++; if (PCval !== 1) begin errors++; $display("FAIL incpc got %h exp 1", PCval); end
        load_mdr(32'h2891_8000); MDRout = 1; IRin = 1; MARin = 1; tick(); idle();
        checks++; if (IRval !== 32'h2891_8000) begin errors++; $display("FAIL ir_load got %h exp 28918000", IRval); end
        checks++; if (MARval !== 32'h2891_8000) begin errors++; $display("FAIL mar_load got %h exp 28918000", MARval); end
        PCout = 1; #1;
        checks++; if (BusMuxOut !== 1) begin errors++; $display("FAIL pc_out got %h exp 1", BusMuxOut); end
        idle(); MDRout = 1; PCin = 1; IncPC = 1; tick(); idle();
        checks++; if (PCval !== 2) begin errors++; $display("FAIL incpc_prio got %h exp 2", PCval); end
        load_mdr(32'hFFFF_FFFF); MDRout = 1; PCin = 1; tick(); idle();
        IncPC = 1; tick(); idle();
        checks++; if (PCval !== 0) begin errors++; $display("FAIL pc_wrap got %h exp 0", PCval); end
    endtask

    task automatic test_mul_div();
        run_alu(32'hFFFF_FFFE, 32'd3, 5'b10000, 1'b0);
        Zhighout = 1; #1;
        checks++; if (BusMuxOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hi got %h exp ffffffff", BusMuxOut); end
        idle(); Zlowout = 1; #1;
        checks++; if (BusMuxOut !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_lo got %h exp fffffffa", BusMuxOut); end
        idle();
        run_alu(32'd20, 32'd6, 5'b01111, 1'b0);
        Zlowout = 1; #1;
`ifdef DATAPATH_DIV_EN
        checks++; if (BusMuxOut !== 32'd3) begin errors++; $display("FAIL div_q got %h exp 3", BusMuxOut); end
`else
        checks++; if (BusMuxOut !== 32'd0) begin errors++; $display("FAIL div_q got %h exp 0", BusMuxOut); end
`endif
        idle(); Zhighout = 1; #1;
`ifdef DATAPATH_DIV_EN
        checks++; if (BusMuxOut !== 32'd2) begin errors++; $display("FAIL div_r got %h exp 2", BusMuxOut); end
`else
        checks++; if (BusMuxOut !== 32'd0) begin errors++; $display("FAIL div_r got %h exp 0", BusMuxOut); end
`endif
        idle();
        run_alu(32'd20, 32'd0, 5'b01111, 1'b0);
        Zlowout = 1; #1;
`ifdef DATAPATH_DIV_EN
        checks++; if (BusMuxOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_q got %h exp ffffffff", BusMuxOut); end
`else
        checks++; if (BusMuxOut !== 32'd0) begin errors++; $display("FAIL div0_q got %h exp 0", BusMuxOut); end
`endif
        idle();
    endtask

    task automatic test_bus_edge();
        load_mdr(32'h0000_0BAD); HIin = 1; MDRout = 1; tick(); idle();
        load_mdr(32'h0000_0C0D); LOin = 1; MDRout = 1; tick(); idle();
        HIout = 1; LOout = 1; MDRout = 1; #1;
        checks++; if (BusMuxOut !== 32'h0BAD) begin errors++; $display("FAIL bus_hi_prio got %h exp bad", BusMuxOut); end
        idle(); R0_15_out = 16'h0004; MDRout = 1; #1;
        checks++; if (BusMuxOut !== 32'h12) begin errors++; $display("FAIL bus_r2_mdr got %h exp 12", BusMuxOut); end
        idle(); R0_15_out = 16'h0030; HIout = 1; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL bus_r4 got %h exp 0", BusMuxOut); end
        idle(); R0_15_out = 16'h000C; #1;
        checks++; if (BusMuxOut !== 32'h12) begin errors++; $display("FAIL bus_low_idx got %h exp 12", BusMuxOut); end
        // Clear alongside a pending transfer wins.
        idle(); load_mdr(32'h55); MDRout = 1; R0in = 1; clear = 1; tick(); idle();
        R0_15_out = 16'h0001; #1;
        checks++; if (BusMuxOut !== 0) begin errors++; $display("FAIL clear_mid got %h exp 0", BusMuxOut); end
        idle();
    endtask

    task automatic test_random_alu();
        logic [4:0]  ops [16];
        logic [31:0] a, b;
        logic [4:0]  op;
        logic        ci;
        logic [63:0] exp_c;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd12, 5'd31};
        for (int it = 0; it < 60; it++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            op = ops[$urandom_range(0, 15)];
            ci = 1'($urandom_range(0, 1));
            if (op == 5'd15 && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) * (b[0] ? 32'hFFFF_FFFF : 32'h1);
            exp_c = model_alu(a, b, op, ci);
            run_alu(a, b, op, ci);
            Zlowout = 1; #1;
            checks++; if (BusMuxOut !== exp_c[31:0]) begin
                errors++; $display("FAIL alu_lo op=%0d a=%h b=%h got %h exp %h", op, a, b, BusMuxOut, exp_c[31:0]);
            end
            idle(); Zhighout = 1; #1;
            checks++; if (BusMuxOut !== exp_c[63:32]) begin
                errors++; $display("FAIL alu_hi op=%0d a=%h b=%h got %h exp %h", op, a, b, BusMuxOut, exp_c[63:32]);
            end
            idle();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_path();
        test_and();
        test_bus_edge();
        test_fetch();
        test_mul_div();
        test_random_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
